// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Request, shared-ALU and response signal bundle for alu_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;
    logic             req1_ready;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_c;

    logic             resp_valid;
    logic             resp_id;
    logic [WIDTH-1:0] resp_data;
    logic             resp_ready;

    logic [15:0]      op_count;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_c,
        output resp_valid, resp_id, resp_data,
        input  resp_ready,
        output op_count
    );

    // Requester / ALU / consumer side
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_c,
        input  resp_valid, resp_id, resp_data,
        output resp_ready,
        input  op_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin arbiter sharing one combinational ALU between two
//            requesters; one operation in flight, registered response.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  wire logic    clk,
    input  wire logic    reset,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_grant0;
    logic             w_grant1;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OPW-1:0]   r_op;
    logic             r_id;
    logic             r_last;
    logic [WIDTH-1:0] r_resp_data;
    logic             r_resp_id;
    logic [15:0]      r_op_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // r_last names the previous winner; on contention the other side wins.
    always_comb begin
        w_next   = r_state;
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        case (r_state)
            IDLE: begin
                if (!reset) begin
                    w_grant0 = bus.req0_valid && (!bus.req1_valid || r_last);
                    w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_last);
                end
                if (w_grant0 || w_grant1) begin
                    w_next = EXEC;
                end
            end
            EXEC: begin
                w_next = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_id        <= 1'b0;
            r_last      <= 1'b1;
            r_resp_data <= '0;
            r_resp_id   <= 1'b0;
            r_op_count  <= 16'd0;
        end else begin
            if (w_grant0 || w_grant1) begin
                r_a    <= w_grant1 ? bus.req1_a  : bus.req0_a;
                r_b    <= w_grant1 ? bus.req1_b  : bus.req0_b;
                r_op   <= w_grant1 ? bus.req1_op : bus.req0_op;
                r_id   <= w_grant1;
                r_last <= w_grant1;
            end
            if (r_state == EXEC) begin
                r_resp_data <= bus.alu_c;
                r_resp_id   <= r_id;
            end
            if ((r_state == RESP) && bus.resp_ready) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.alu_a      = r_a;
    assign bus.alu_b      = r_b;
    assign bus.alu_op     = r_op;
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_data  = r_resp_data;
    assign bus.op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed self-checking bench for alu_arbiter with a reference ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    alu_arbiter_if #(.WIDTH(32), .OPW(3)) bus ();

    alu_arbiter #(.WIDTH(32), .OPW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic logic [31:0] alu_model(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [2:0]  op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b110:  return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    assign bus.alu_c = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.resp_ready = 1'b0;

        // Reset: no grant even with a valid request
        step();
        step();
        bus.req0_valid = 1'b1;
        #1;
        check_eq("rst_ready0", 32'(bus.req0_ready), 32'd0);
        check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);

        // Single request from req0
        reset = 1'b0;
        bus.req0_a = 32'hF000_1000; bus.req0_b = 32'd1; bus.req0_op = 3'b000;
        #1;
        check_eq("single_ready0", 32'(bus.req0_ready), 32'd1);
        check_eq("single_ready1", 32'(bus.req1_ready), 32'd0);
        check_eq("rst_op_count", 32'(bus.op_count), 32'd0);
        check_eq("rst_resp_data", bus.resp_data, 32'd0);
        check_eq("rst_alu_a", bus.alu_a, 32'd0);
        step();
        bus.req0_valid = 1'b0;
        #1;
        check_eq("exec_ready0", 32'(bus.req0_ready), 32'd0);
        check_eq("exec_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("exec_alu_a", bus.alu_a, 32'hF000_1000);
        check_eq("exec_alu_b", bus.alu_b, 32'd1);
        step();
        #1;
        check_eq("single_resp_valid", 32'(bus.resp_valid), 32'd1);
        check_eq("single_resp_id", 32'(bus.resp_id), 32'd0);
        check_eq("single_resp_data", bus.resp_data, 32'hF000_1001);
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        #1;
        check_eq("single_op_count", 32'(bus.op_count), 32'd1);
        check_eq("single_idle_valid", 32'(bus.resp_valid), 32'd0);

        // Reset while req1's operation is in EXEC
        bus.req1_valid = 1'b1; bus.req1_a = 32'd5; bus.req1_b = 32'd9; bus.req1_op = 3'b000;
        #1;
        check_eq("rmid_ready1", 32'(bus.req1_ready), 32'd1);
        step();
        bus.req1_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check_eq("rmid_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("rmid_op_count", 32'(bus.op_count), 32'd0);
        check_eq("rmid_alu_a", bus.alu_a, 32'd0);

        // Contention: grants alternate starting with req0
        bus.req0_valid = 1'b1; bus.req0_a = 32'd10; bus.req0_b = 32'd3; bus.req0_op = 3'b001;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd6;  bus.req1_b = 32'd3; bus.req1_op = 3'b010;
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("cont_ready0", 32'(bus.req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("cont_ready1", 32'(bus.req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
            step();
            #1;
            check_eq("cont_exec_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
            check_eq("cont_exec_valid", 32'(bus.resp_valid), 32'd0);
            step();
            #1;
            check_eq("cont_resp_valid", 32'(bus.resp_valid), 32'd1);
            check_eq("cont_resp_id", 32'(bus.resp_id), (k % 2 == 1) ? 32'd1 : 32'd0);
            check_eq("cont_resp_data", bus.resp_data, (k % 2 == 1) ? 32'd2 : 32'd7);
            step();
            #1;
            check_eq("cont_op_count", 32'(bus.op_count), 32'(k + 1));
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.resp_ready = 1'b0;

        // Backpressure on a req0 op, req1 becoming valid during EXEC
        bus.req0_valid = 1'b1; bus.req0_a = 32'h0000_00F0; bus.req0_b = 32'd4; bus.req0_op = 3'b110;
        #1;
        check_eq("bp_ready0", 32'(bus.req0_ready), 32'd1);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 32'hFFFF_FFFF; bus.req1_b = 32'd1; bus.req1_op = 3'b000;
        #1;
        check_eq("late_exec_ready1", 32'(bus.req1_ready), 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
            check_eq("bp_resp_data", bus.resp_data, 32'h0000_0F00);
            check_eq("bp_resp_id", 32'(bus.resp_id), 32'd0);
            check_eq("bp_ready1", 32'(bus.req1_ready), 32'd0);
            bus.req1_a = 32'(i);
            step();
        end
        bus.req1_a = 32'hFFFF_FFFF;
        bus.resp_ready = 1'b1;
        #1;
        check_eq("bp_hs_ready1", 32'(bus.req1_ready), 32'd0);
        check_eq("bp_hs_data", bus.resp_data, 32'h0000_0F00);
        step();
        bus.resp_ready = 1'b0;
        #1;
        check_eq("late_idle_ready1", 32'(bus.req1_ready), 32'd1);
        check_eq("bp_op_count", 32'(bus.op_count), 32'd5);
        step();
        bus.req1_valid = 1'b0;
        step();
        #1;
        check_eq("late_resp_data", bus.resp_data, 32'd0);
        check_eq("late_resp_id", 32'(bus.resp_id), 32'd1);
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        #1;
        check_eq("late_op_count", 32'(bus.op_count), 32'd6);

        // Counter wrap
        force dut.r_op_count = 16'hFFFF;
        #1;
        release dut.r_op_count;
        #1;
        check_eq("wrap_preload", 32'(bus.op_count), 32'h0000_FFFF);
        bus.req0_valid = 1'b1; bus.req0_a = 32'd7; bus.req0_b = 32'd5; bus.req0_op = 3'b100;
        step();
        bus.req0_valid = 1'b0;
        step();
        bus.resp_ready = 1'b1;
        #1;
        check_eq("wrap_resp_data", bus.resp_data, 32'd2);
        step();
        bus.resp_ready = 1'b0;
        #1;
        check_eq("wrap_op_count", 32'(bus.op_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand and result width; it SHALL match the shared ALU.
REQ-002 SHALL have parameter OPW, default 3, meaning the ALUOp width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1, requester n has an operation pending.
REQ-006 SHALL have ports req0_a, req0_b / req1_a, req1_b, input, WIDTH, the requester operands.
REQ-007 SHALL have ports req0_op / req1_op, input, OPW, the requester ALUOp (opaque to this block).
REQ-008 SHALL have ports req0_ready / req1_ready, output, 1, the request is accepted this cycle.
REQ-009 SHALL have ports alu_a, alu_b (output, WIDTH), alu_op (output, OPW) and alu_c (input, WIDTH), connecting to the combinational ALU A/B/ALUOp/C.
REQ-010 SHALL have port resp_valid, output, 1, a result is available.
REQ-011 SHALL have port resp_id, output, 1, the requester that owns the result (0 or 1).
REQ-012 SHALL have port resp_data, output, WIDTH, the registered ALU result.
REQ-013 SHALL have port resp_ready, input, 1, the consumer accepts the result.
REQ-014 SHALL have port op_count, output, 16, the number of completed response handshakes.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-016 In IDLE with at least one valid request, SHALL assert exactly one reqN_ready combinationally in that cycle.
REQ-017 In IDLE, SHALL latch the winner's a, b, op and id into internal operand registers and go to EXEC.
REQ-018 reqN_ready SHALL be 0 in EXEC and RESP, and in IDLE when no request is valid.
REQ-019 Arbitration SHALL be round-robin: if only one request is valid, grant it; if both are valid, grant the requester not granted last.
REQ-020 The last-grant register SHALL update only on a grant.
REQ-021 In EXEC, alu_a/alu_b/alu_op SHALL be driven from the operand registers.
REQ-022 At the end of EXEC, SHALL capture alu_c into resp_data, set resp_id to the latched id, and go to RESP.
REQ-023 alu_a/alu_b/alu_op SHALL hold the operand registers in all states, which is 0 after reset.
REQ-024 In RESP, resp_valid SHALL be 1.
REQ-025 While in RESP, resp_data and resp_id SHALL be stable until resp_valid && resp_ready.
REQ-026 On the RESP handshake, SHALL return to IDLE and increment op_count.
REQ-027 op_count SHALL wrap from 16'hFFFF to 0.
REQ-028 Latency from grant to resp_valid SHALL be 2 cycles.
REQ-029 Minimum spacing between grants SHALL be 3 cycles (no grant in the handshake cycle itself).
REQ-030 resp_valid SHALL be 0 in IDLE and EXEC.
REQ-031 resp_ready while not in RESP SHALL be ignored.
REQ-032 A requester that drops valid before being granted SHALL lose nothing: no state is kept for ungranted requests.
REQ-033 Request inputs SHALL be sampled only in IDLE; changes during EXEC/RESP SHALL have no effect on the in-flight operation.
REQ-034 The result SHALL be the full WIDTH bits of alu_c; the block SHALL perform no arithmetic on it.

Reset
REQ-035 On reset, SHALL go to IDLE and clear operand registers, resp_data, resp_id and op_count to 0.
REQ-036 On reset, SHALL set last-grant to 1, so req0 wins the first contention.
REQ-037 Reset in EXEC or RESP SHALL abort the operation and discard the result.
REQ-038 resp_valid SHALL be 0 in the cycle after reset.
REQ-039 reqN_ready SHALL be 0 during a reset cycle.

Verification
REQ-040 The bench SHALL drive alu_c from a reference model of the real ALU.
REQ-041 Single request: req0 with a=32'hF0001000, b=1, op=3'b000 -> req0_ready in the first IDLE cycle; resp_valid 2 cycles later with resp_id=0 and resp_data=model(F0001000,1,000); op_count=1 after the handshake.
REQ-042 Contention: both valid continuously -> grants alternate 0,1,0,1; resp_id sequence matches; no requester is granted twice in a row.
REQ-043 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_data and resp_id are held; no reqN_ready is asserted; operand changes on req1 do not alter resp_data.
REQ-044 Reset mid-operation: assert reset in EXEC -> the next cycle shows IDLE, resp_valid=0, op_count=0, and the next contention goes to req0.
REQ-045 Wrap: preload via 65536 handshakes (or force) -> op_count goes FFFF->0000 on the next handshake.
REQ-046 Late valid: req1 asserts valid during EXEC of a req0 op -> req1 is granted only in the IDLE cycle after the req0 handshake.
